// File: rtl/asteroids_pkg.sv
// Shared entity-word layout, screen bounds and the shot reader state type.
package asteroids_pkg;

  // Entity word field positions
  localparam int ACTIVE_BIT = 33;
  localparam int SPRITE_HI  = 32;
  localparam int SPRITE_LO  = 30;
  localparam int Y_HI       = 25;
  localparam int Y_LO       = 16;
  localparam int X_HI       = 15;
  localparam int X_LO       = 6;

  // Visible screen size; coordinates at or beyond these are off-screen
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    EMIT,
    CULL,
    DONE
  } shot_rd_state_e;

endpackage

// File: rtl/shot_bounds_check.sv
// Combinational on-screen test for a 10-bit entity position.
// Unsigned compare: a coordinate that wrapped below zero reads as a large
// value and is therefore off-screen.
module shot_bounds_check #(
  parameter int X_MAX = 640,
  parameter int Y_MAX = 480
) (
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       on_screen_o
);

  localparam logic [10:0] XLIM = 11'(X_MAX);
  localparam logic [10:0] YLIM = 11'(Y_MAX);

  assign on_screen_o = ({1'b0, x_i} < XLIM) && ({1'b0, y_i} < YLIM);

endmodule

// File: rtl/shot_reader.sv
// Per-frame shot array reader: snapshots the array on frame_start, walks every
// slot in ascending order, emits one draw beat per on-screen active shot and a
// delete strobe per off-screen active shot.
// Draw handshake: draw_valid rises with a stable payload and stays high, payload
// unchanged, until the clock edge where draw_valid && draw_ready; that edge
// completes the beat. draw_ready while draw_valid is low has no effect.
module shot_reader
  import asteroids_pkg::*;
#(
  parameter int SHOT_COUNT  = 10,
  parameter int ENTITY_SIZE = 34,
  parameter int X_MAX       = SCREEN_W,
  parameter int Y_MAX       = SCREEN_H,
  parameter int IDX_W       = $clog2(SHOT_COUNT)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              frame_start,
  input  logic [SHOT_COUNT*ENTITY_SIZE-1:0] shots_data,
  input  logic                              draw_ready,
  output logic                              draw_valid,
  output logic [9:0]                        draw_x,
  output logic [9:0]                        draw_y,
  output logic [2:0]                        draw_sprite,
  output logic [IDX_W-1:0]                  draw_index,
  output logic                              delete_shot,
  output logic [IDX_W-1:0]                  shot_address,
  output logic                              busy,
  output logic                              scan_done,
  output logic                              frame_overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SHOT_COUNT - 1);

  shot_rd_state_e                    state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [SHOT_COUNT*ENTITY_SIZE-1:0] snap_q, snap_d;
  logic                              overrun_q, overrun_d;
  logic                              advance;

  logic                              draw_valid_q, draw_valid_d;
  logic [9:0]                        draw_x_q, draw_x_d;
  logic [9:0]                        draw_y_q, draw_y_d;
  logic [2:0]                        draw_sprite_q, draw_sprite_d;
  logic [IDX_W-1:0]                  draw_index_q, draw_index_d;
  logic                              delete_q, delete_d;
  logic [IDX_W-1:0]                  addr_q, addr_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;

  // Slot currently under evaluation, taken from the snapshot
  logic [ENTITY_SIZE-1:0] snap_words [SHOT_COUNT];
  for (genvar g = 0; g < SHOT_COUNT; g++) begin : g_unpack
    assign snap_words[g] = snap_q[g*ENTITY_SIZE +: ENTITY_SIZE];
  end

  logic [ENTITY_SIZE-1:0] cur_ent;
  logic                   cur_active;
  logic [2:0]             cur_sprite;
  logic [9:0]             cur_x;
  logic [9:0]             cur_y;
  logic                   cur_on_screen;
  logic                   cur_unused;

  assign cur_ent    = snap_words[idx_q];
  assign cur_active = cur_ent[ACTIVE_BIT];
  assign cur_sprite = cur_ent[SPRITE_HI:SPRITE_LO];
  assign cur_x      = cur_ent[X_HI:X_LO];
  assign cur_y      = cur_ent[Y_HI:Y_LO];
  // Queue and direction fields are carried in the snapshot but not consumed here
  assign cur_unused = ^{cur_ent[SPRITE_LO-1:Y_HI+1], cur_ent[X_LO-1:0]};

  shot_bounds_check #(
    .X_MAX(X_MAX),
    .Y_MAX(Y_MAX)
  ) u_bounds (
    .x_i        (cur_x),
    .y_i        (cur_y),
    .on_screen_o(cur_on_screen)
  );

  // State, scan bookkeeping and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      snap_q        <= '0;
      overrun_q     <= 1'b0;
      draw_valid_q  <= 1'b0;
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      draw_sprite_q <= '0;
      draw_index_q  <= '0;
      delete_q      <= 1'b0;
      addr_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      overrun_q     <= overrun_d;
      draw_valid_q  <= draw_valid_d;
      draw_x_q      <= draw_x_d;
      draw_y_q      <= draw_y_d;
      draw_sprite_q <= draw_sprite_d;
      draw_index_q  <= draw_index_d;
      delete_q      <= delete_d;
      addr_q        <= addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next state: one SCAN cycle per slot, detours through EMIT or CULL
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    overrun_d = overrun_q;
    advance   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = SCAN;
          idx_d   = '0;
          snap_d  = shots_data;
        end
      end
      SCAN: begin
        if (!cur_active)         advance = 1'b1;
        else if (!cur_on_screen) state_d = CULL;
        else                     state_d = EMIT;
      end
      EMIT: begin
        if (draw_valid_q && draw_ready) advance = 1'b1;
      end
      CULL:    advance = 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = SCAN;
      end
    end
    // A frame arriving anywhere outside IDLE (DONE included) is dropped and flagged
    if (frame_start && state_q != IDLE) overrun_d = 1'b1;
  end

  // Output values for the next cycle, derived from the state being entered
  always_comb begin
    draw_valid_d  = (state_d == EMIT);
    draw_x_d      = '0;
    draw_y_d      = '0;
    draw_sprite_d = '0;
    draw_index_d  = '0;
    delete_d      = (state_d == CULL);
    addr_d        = '0;
    busy_d        = (state_d != IDLE);
    done_d        = (state_q == DONE);
    if (state_d == EMIT) begin
      draw_x_d      = cur_x;
      draw_y_d      = cur_y;
      draw_sprite_d = cur_sprite;
      draw_index_d  = idx_q;
    end
    if (state_d == CULL) addr_d = idx_q;
  end

  assign draw_valid    = draw_valid_q;
  assign draw_x        = draw_x_q;
  assign draw_y        = draw_y_q;
  assign draw_sprite   = draw_sprite_q;
  assign draw_index    = draw_index_q;
  assign delete_shot   = delete_q;
  assign shot_address  = addr_q;
  assign busy          = busy_q;
  assign scan_done     = done_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_shot_reader.sv
// Bench for shot_reader: inputs driven on the falling edge, outputs sampled
// 1 time unit after the falling edge. Expected draw/delete events are queued
// as each scenario is set up and popped by the monitor as the DUT emits them.
module tb_shot_reader;

  localparam int SC = 10;
  localparam int EW = 34;
  localparam int IW = 4;
  localparam int BW = 28;  // {del, idx[3:0], sprite[2:0], x[9:0], y[9:0]}

  logic             clk;
  logic             reset_n;
  logic             frame_start;
  logic [SC*EW-1:0] shots_data;
  logic             draw_ready;
  logic             draw_valid;
  logic [9:0]       draw_x;
  logic [9:0]       draw_y;
  logic [2:0]       draw_sprite;
  logic [IW-1:0]    draw_index;
  logic             delete_shot;
  logic [IW-1:0]    shot_address;
  logic             busy;
  logic             scan_done;
  logic             frame_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;
  logic [BW-1:0] exp_q[$];

  shot_reader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .shots_data   (shots_data),
    .draw_ready   (draw_ready),
    .draw_valid   (draw_valid),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .draw_sprite  (draw_sprite),
    .draw_index   (draw_index),
    .delete_shot  (delete_shot),
    .shot_address (shot_address),
    .busy         (busy),
    .scan_done    (scan_done),
    .frame_overrun(frame_overrun)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] make_ent(logic act, logic [2:0] spr,
                                             logic [9:0] x, logic [9:0] y);
    logic [EW-1:0] e;
    e        = '0;
    e[33]    = act;
    e[32:30] = spr;
    e[29:26] = 4'($urandom_range(0, 15));
    e[25:16] = y;
    e[15:6]  = x;
    e[5:0]   = 6'($urandom_range(0, 63));
    return e;
  endfunction

  function automatic logic [BW-1:0] beat(logic del, logic [IW-1:0] idx, logic [2:0] spr,
                                         logic [9:0] x, logic [9:0] y);
    return {del, idx, spr, x, y};
  endfunction

  function automatic logic [35:0] all_outs();
    return {draw_valid, draw_x, draw_y, draw_sprite, draw_index, delete_shot,
            shot_address, busy, scan_done, frame_overrun};
  endfunction

  task automatic set_slot(input int i, input logic act, input logic [2:0] spr,
                          input logic [9:0] x, input logic [9:0] y);
    shots_data[i*EW +: EW] = make_ent(act, spr, x, y);
  endtask

  // Pulse frame_start from the current falling edge; lat = falling edges until
  // scan_done is seen, or -1 if it never arrives.
  task automatic run_frame(output int lat);
    frame_start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1) frame_start = 1'b0;
      #1;
      if (scan_done) begin
        lat = c;
        break;
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [BW-1:0] got;
    logic [BW-1:0] exp;
    #1;
    if (mon_en) begin
      n_checks++;
      if (draw_valid && delete_shot) begin
        n_fail++;
        $display("FAIL excl: draw_valid and delete_shot both high at %0t", $time);
      end
      if (draw_valid && draw_ready) begin
        got = beat(1'b0, draw_index, draw_sprite, draw_x, draw_y);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat: unexpected draw beat got=%h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL beat: got=%h expected=%h", got, exp);
          end
        end
      end
      if (delete_shot) begin
        got = beat(1'b1, shot_address, 3'd0, 10'd0, 10'd0);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL delete: unexpected delete got=%h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL delete: got=%h expected=%h", got, exp);
          end
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n     = 1'b0;
    frame_start = 1'b0;
    draw_ready  = 1'b0;
    shots_data  = '0;
    #3;
    n_checks++;
    if (all_outs() !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got=%h expected=0", all_outs());
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic test_two_beats();
    int lat;
    @(negedge clk);
    shots_data = '0;
    set_slot(0, 1'b1, 3'd1, 10'd100, 10'd50);
    set_slot(3, 1'b1, 3'd2, 10'd200, 10'd60);
    draw_ready = 1'b1;
    exp_q.push_back(beat(1'b0, 4'd0, 3'd1, 10'd100, 10'd50));
    exp_q.push_back(beat(1'b0, 4'd3, 3'd2, 10'd200, 10'd60));
    run_frame(lat);
    n_checks++;
    if (lat != SC + 4) begin
      n_fail++;
      $display("FAIL two_beats_latency: got=%0d expected=%0d", lat, SC + 4);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL two_beats_left: got=%0d pending expected=0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    int lat;
    logic [25:0] first;
    @(negedge clk);
    shots_data = '0;
    set_slot(0, 1'b1, 3'd4, 10'd50, 10'd40);
    draw_ready = 1'b0;
    exp_q.push_back(beat(1'b0, 4'd0, 3'd4, 10'd50, 10'd40));
    fork
      run_frame(lat);
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          #1;
          if (draw_valid) break;
        end
        n_checks++;
        if (draw_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_valid_rise: got=%b expected=1", draw_valid);
        end
        first = {draw_index, draw_sprite, draw_x, draw_y};
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          #1;
          n_checks++;
          if (draw_valid !== 1'b1 || {draw_index, draw_sprite, draw_x, draw_y} !== first) begin
            n_fail++;
            $display("FAIL stall_hold: valid=%b payload=%h expected valid=1 payload=%h",
                     draw_valid, {draw_index, draw_sprite, draw_x, draw_y}, first);
          end
        end
        @(negedge clk);
        draw_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (draw_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_complete: valid=%b expected=0", draw_valid);
        end
      end
    join
    n_checks++;
    if (lat != SC + 3 + 5) begin
      n_fail++;
      $display("FAIL stall_latency: got=%0d expected=%0d", lat, SC + 8);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_left: got=%0d pending expected=0", exp_q.size());
    end
  endtask

  task automatic test_cull();
    int lat;
    @(negedge clk);
    shots_data = '0;
    set_slot(2, 1'b1, 3'd3, 10'd1023, 10'd10);
    set_slot(5, 1'b1, 3'd4, 10'd300, 10'd480);
    draw_ready = 1'b1;
    exp_q.push_back(beat(1'b1, 4'd2, 3'd0, 10'd0, 10'd0));
    exp_q.push_back(beat(1'b1, 4'd5, 3'd0, 10'd0, 10'd0));
    run_frame(lat);
    n_checks++;
    if (lat != SC + 4) begin
      n_fail++;
      $display("FAIL cull_latency: got=%0d expected=%0d", lat, SC + 4);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL cull_left: got=%0d pending expected=0", exp_q.size());
    end
  endtask

  task automatic test_boundary();
    int lat;
    @(negedge clk);
    shots_data = '0;
    set_slot(1, 1'b0, 3'd3, 10'd1023, 10'd1023);
    set_slot(4, 1'b1, 3'd7, 10'd639, 10'd479);
    set_slot(6, 1'b1, 3'd1, 10'd640, 10'd0);
    set_slot(9, 1'b1, 3'd2, 10'd0, 10'd479);
    draw_ready = 1'b1;
    exp_q.push_back(beat(1'b0, 4'd4, 3'd7, 10'd639, 10'd479));
    exp_q.push_back(beat(1'b1, 4'd6, 3'd0, 10'd0, 10'd0));
    exp_q.push_back(beat(1'b0, 4'd9, 3'd2, 10'd0, 10'd479));
    run_frame(lat);
    n_checks++;
    if (lat != SC + 5) begin
      n_fail++;
      $display("FAIL boundary_latency: got=%0d expected=%0d", lat, SC + 5);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL boundary_left: got=%0d pending expected=0", exp_q.size());
    end
  endtask

  task automatic test_all_inactive();
    int lat;
    @(negedge clk);
    for (int i = 0; i < SC; i++) begin
      set_slot(i, 1'b0, 3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)),
               10'($urandom_range(0, 1023)));
    end
    run_frame(lat);
    n_checks++;
    if (lat != SC + 2) begin
      n_fail++;
      $display("FAIL idle_latency: got=%0d expected=%0d", lat, SC + 2);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({busy, scan_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after: busy=%b scan_done=%b expected 0 0", busy, scan_done);
    end
  endtask

  task automatic test_snapshot_overrun();
    int lat;
    @(negedge clk);
    n_checks++;
    if (frame_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_pre: got=%b expected=0", frame_overrun);
    end
    shots_data = '0;
    set_slot(1, 1'b1, 3'd3, 10'd10, 10'd20);
    set_slot(7, 1'b1, 3'd5, 10'd600, 10'd470);
    draw_ready = 1'b1;
    exp_q.push_back(beat(1'b0, 4'd1, 3'd3, 10'd10, 10'd20));
    exp_q.push_back(beat(1'b0, 4'd7, 3'd5, 10'd600, 10'd470));
    fork
      run_frame(lat);
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < SC; i++) set_slot(i, 1'b1, 3'd6, 10'd5, 10'd5);
        repeat (2) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
      end
    join
    n_checks++;
    if (lat != SC + 4) begin
      n_fail++;
      $display("FAIL snap_latency: got=%0d expected=%0d", lat, SC + 4);
    end
    n_checks++;
    if (frame_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got=%b expected=1", frame_overrun);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL snap_left: got=%0d pending expected=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_emit();
    int lat;
    @(negedge clk);
    mon_en     = 1'b0;
    shots_data = '0;
    set_slot(0, 1'b1, 3'd4, 10'd123, 10'd321);
    draw_ready  = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (draw_valid) break;
      @(negedge clk);
    end
    n_checks++;
    if (draw_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_emit_valid: got=%b expected=1", draw_valid);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== 36'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outs: got=%h expected=0", all_outs());
    end
    @(negedge clk);
    reset_n    = 1'b1;
    draw_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(beat(1'b0, 4'd0, 3'd4, 10'd123, 10'd321));
    mon_en = 1'b1;
    run_frame(lat);
    n_checks++;
    if (lat != SC + 3) begin
      n_fail++;
      $display("FAIL rst_rescan_latency: got=%0d expected=%0d", lat, SC + 3);
    end
    n_checks++;
    if (exp_q.size() != 0 || frame_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rescan: pending=%0d overrun=%b expected 0 0",
               exp_q.size(), frame_overrun);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_two_beats();
    test_stall();
    test_cull();
    test_boundary();
    test_all_inactive();
    test_snapshot_overrun();
    test_reset_mid_emit();
    @(negedge clk);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
